color_frame_classifier: RTL and testbench
=========================================

// Module: color_frame_classifier
// PURPOSE
//  Downstream consumer of the RGB332 dual-port frame buffer filled by the camera capture logic.
//  On START, scans one stored 176x144 frame through the buffer's read port, one address per cycle.
//  Counts red-dominant and blue-dominant pixels and reports a per-frame colour verdict.
//  Runs on the buffer's read-side clock.
// PARAMETERS
//  WIDTH        176  frame width in pixels
//  HEIGHT       144  frame height in pixels
//  RD_LATENCY   1    cycles from READ_ADDR to valid PIXEL_IN (M9K registered read)
//  R_MIN        3'd5 minimum R field for a red pixel
//  B_MIN        2'd2 minimum B field for a blue pixel
//  OTHER_MAX    3'd2 maximum value of each non-dominant channel (B compared as {1'b0,B})
//  MIN_COUNT    15'd500 minimum winning count for a non-NONE verdict
// PORTS
//  CLOCK       in   1   single clock (buffer read clock)
//  RESET       in   1   synchronous, active-low reset
//  START       in   1   request one frame scan; sampled only in IDLE
//  ABORT       in   1   cancel scan in progress; no DONE is produced
//  PIXEL_IN    in   8   RGB332 from buffer: R=[7:5] G=[4:2] B=[1:0]
//  READ_ADDR   out  15  buffer read address = x + y*WIDTH
//  BUSY        out  1   high in SCAN/DRAIN/DECIDE
//  DONE        out  1   one-cycle pulse when RESULT/counts update
//  RESULT      out  2   00 NONE, 01 RED, 10 BLUE (11 never driven)
//  RED_COUNT   out  15  red pixel count of last completed frame
//  BLUE_COUNT  out  15  blue pixel count of last completed frame
// BEHAVIOUR
//  Reset (RESET==0 at CLOCK edge): state IDLE; all outputs 0; internal counters 0; reset beats START/ABORT.
//  FSM: IDLE -START-> SCAN -last addr issued-> DRAIN -RD_LATENCY cycles-> DECIDE -1 cycle-> IDLE.
//  ABORT in SCAN/DRAIN/DECIDE -> IDLE next cycle, no DONE; RESULT/RED_COUNT/BLUE_COUNT keep old values.
//  ABORT in IDLE: ignored. START && ABORT in IDLE: scan does not start.
//  START outside IDLE: ignored (no queuing).
//  SCAN: x/y counters; READ_ADDR steps 0..WIDTH*HEIGHT-1 (0..25343), one per cycle.
//   - x wraps WIDTH-1 -> 0 with y+1.
//   - READ_ADDR returns to 0 once SCAN is left.
//  Valid-tag shift register (depth RD_LATENCY) marks PIXEL_IN for the addresses issued in SCAN.
//   - Exactly WIDTH*HEIGHT pixels are classified per frame.
//  Pixel classification (combinational, per valid pixel):
//   - red:  R>=R_MIN && G<=OTHER_MAX && {1'b0,B}<=OTHER_MAX.
//   - blue: B>=B_MIN && R<=OTHER_MAX && G<=OTHER_MAX.
//   - With the default parameters, red and blue are mutually exclusive.
//  Working counters: 15 bit, cleared on entry to SCAN, saturate at 15'h7FFF (unreachable at default size).
//  DECIDE:
//   - RED_COUNT/BLUE_COUNT <= working counts.
//   - RESULT <= RED if red>blue && red>=MIN_COUNT; BLUE if blue>red && blue>=MIN_COUNT; otherwise NONE (ties -> NONE).
//   - DONE=1 for exactly this cycle.
//  Latency: START edge to DONE = 1 + WIDTH*HEIGHT + RD_LATENCY + 1 cycles (25347 at defaults).
//  BUSY falls in the same cycle that DONE falls.
// STRUCTURE
//  Shared package:
//   - SCREEN_WIDTH/HEIGHT.
//   - RGB332 field slices.
//   - RESULT codes (CLR_NONE/CLR_RED/CLR_BLUE).
//   - FSM state encodings.
//  Sub-module rgb332_classifier: combinational, PIXEL_IN + thresholds -> is_red, is_blue.
//  Top level holds the FSM, address counters, valid pipeline, counters and decision.
// TESTING
//  1 Reset with START=1 held: outputs all 0, BUSY stays 0 while RESET=0; first START after release starts scan.
//  2 Memory model all 8'hE0:
//    - RED_COUNT=25344, BLUE_COUNT=0, RESULT=01.
//    - DONE 25347 cycles after START.
//  3 Left 88 columns 8'h03, right 88 columns 8'hE0 (12672 each): tie -> RESULT=00, both counts 12672.
//  4 400 pixels 8'h03, rest 8'h00: BLUE_COUNT=400 < MIN_COUNT -> RESULT=00; then 600 blue -> RESULT=10.
//  5 ABORT at address 10000:
//    - BUSY low next cycle, no DONE, prior RESULT/counts unchanged.
//    - Rerun completes normally.
//  6 START pulses during SCAN ignored; READ_ADDR monotonic 0..25343 with row wrap at 175->176, exactly one DONE.

Source files
------------

// File: rtl/color_frame_classifier_pkg.sv
// Shared definitions for the RGB332 frame colour classifier:
// frame geometry, RGB332 field accessors, verdict codes, FSM states
// and the per-frame verdict rule.
package color_frame_classifier_pkg;

  localparam int SCREEN_WIDTH  = 176;
  localparam int SCREEN_HEIGHT = 144;
  localparam int ADDR_W        = 15;
  localparam int CNT_W         = 15;

  typedef enum logic [1:0] {
    CLR_NONE = 2'b00,
    CLR_RED  = 2'b01,
    CLR_BLUE = 2'b10
  } color_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DECIDE = 2'd3
  } state_t;

  // RGB332 layout: R=[7:5] G=[4:2] B=[1:0]
  function automatic logic [2:0] r_field(input logic [7:0] pix);
    return pix[7:5];
  endfunction

  function automatic logic [2:0] g_field(input logic [7:0] pix);
    return pix[4:2];
  endfunction

  function automatic logic [1:0] b_field(input logic [7:0] pix);
    return pix[1:0];
  endfunction

  // Strict majority plus a minimum count; ties always give NONE.
  function automatic color_t decide_color(input logic [CNT_W-1:0] red,
                                          input logic [CNT_W-1:0] blue,
                                          input logic [CNT_W-1:0] min_count);
    if (red > blue && red >= min_count) return CLR_RED;
    if (blue > red && blue >= min_count) return CLR_BLUE;
    return CLR_NONE;
  endfunction

endpackage

// File: rtl/rgb332_classifier.sv
// Combinational per-pixel test: is this RGB332 pixel red-dominant or
// blue-dominant. The 2-bit B field is zero-extended before comparing
// against the 3-bit "other channel" ceiling.
module rgb332_classifier
  import color_frame_classifier_pkg::*;
(
  input  logic [7:0] pixel,
  input  logic [2:0] r_min,
  input  logic [1:0] b_min,
  input  logic [2:0] other_max,
  output logic       is_red,
  output logic       is_blue
);

  assign is_red  = (r_field(pixel) >= r_min) &&
                   (g_field(pixel) <= other_max) &&
                   ({1'b0, b_field(pixel)} <= other_max);

  assign is_blue = (b_field(pixel) >= b_min) &&
                   (r_field(pixel) <= other_max) &&
                   (g_field(pixel) <= other_max);

endmodule

// File: rtl/color_frame_classifier.sv
// Scans one stored frame out of the dual-port buffer, one read address
// per cycle, counts red- and blue-dominant pixels and publishes a verdict.
//
// Control protocol: start is a request sampled only while idle (busy=0);
// there is no queuing. done is a single-cycle pulse, and result/counts
// take their new values on the clock edge that ends that pulse. abort
// cancels any active scan without a done pulse and leaves the previously
// published result and counts untouched.
module color_frame_classifier
  import color_frame_classifier_pkg::*;
#(
  parameter int               WIDTH      = SCREEN_WIDTH,
  parameter int               HEIGHT     = SCREEN_HEIGHT,
  parameter int               RD_LATENCY = 1,
  parameter logic [2:0]       R_MIN      = 3'd5,
  parameter logic [1:0]       B_MIN      = 2'd2,
  parameter logic [2:0]       OTHER_MAX  = 3'd2,
  parameter logic [CNT_W-1:0] MIN_COUNT  = 15'd500
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        pixel_in,
  output logic [ADDR_W-1:0] read_addr,
  output logic              busy,
  output logic              done,
  output logic [1:0]        result,
  output logic [CNT_W-1:0]  red_count,
  output logic [CNT_W-1:0]  blue_count,
  output logic [1:0]        fsm_state
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int DW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [XW-1:0]     X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0]     Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);
  localparam logic [DW-1:0]     D_LAST   = DW'(RD_LATENCY - 1);

  state_t                state;
  state_t                state_next;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [ADDR_W-1:0]     row_base;
  logic [RD_LATENCY-1:0] valid_sr;
  logic [DW-1:0]         drain_cnt;
  logic [CNT_W-1:0]      red_work;
  logic [CNT_W-1:0]      blue_work;
  logic                  is_red;
  logic                  is_blue;
  logic                  pix_valid;
  logic                  scan_start;
  logic                  last_addr;
  color_t                verdict;

  assign scan_start = (state == ST_IDLE) && start && !abort;
  assign last_addr  = (x == X_LAST) && (y == Y_LAST);
  assign pix_valid  = valid_sr[RD_LATENCY-1];
  assign verdict    = decide_color(red_work, blue_work, MIN_COUNT);

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DECIDE) && !abort;
  assign fsm_state = state;
  // row_base tracks y*WIDTH so the address needs no multiplier.
  assign read_addr = (state == ST_SCAN) ? (row_base + ADDR_W'(x)) : '0;

  rgb332_classifier u_classifier (
    .pixel     (pixel_in),
    .r_min     (R_MIN),
    .b_min     (B_MIN),
    .other_max (OTHER_MAX),
    .is_red    (is_red),
    .is_blue   (is_blue)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic; abort wins over normal progress in any busy state.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (scan_start) state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (abort)          state_next = ST_IDLE;
        else if (last_addr) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)                    state_next = ST_IDLE;
        else if (drain_cnt == D_LAST) state_next = ST_DECIDE;
      end
      ST_DECIDE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Raster x/y walk; held at zero outside SCAN so each scan starts at address 0.
  always_ff @(posedge clock) begin
    if (!reset || state != ST_SCAN) begin
      x        <= '0;
      y        <= '0;
      row_base <= '0;
    end else if (x == X_LAST) begin
      x        <= '0;
      y        <= y + 1'b1;
      row_base <= row_base + ROW_STEP;
    end else begin
      x <= x + 1'b1;
    end
  end

  // Valid tags follow each issued address through the buffer read latency.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_sr <= '0;
    end else begin
      valid_sr[0] <= (state == ST_SCAN) && !abort;
      for (int i = 1; i < RD_LATENCY; i++) valid_sr[i] <= valid_sr[i-1];
    end
  end

  // Counts the cycles spent waiting for the last read to return.
  always_ff @(posedge clock) begin
    if (!reset || state != ST_DRAIN) drain_cnt <= '0;
    else                             drain_cnt <= drain_cnt + 1'b1;
  end

  // Working pixel counters, cleared at scan start and saturating at all-ones.
  always_ff @(posedge clock) begin
    if (!reset || scan_start) begin
      red_work  <= '0;
      blue_work <= '0;
    end else if (pix_valid) begin
      if (is_red && red_work != '1)   red_work  <= red_work + 1'b1;
      if (is_blue && blue_work != '1) blue_work <= blue_work + 1'b1;
    end
  end

  // Publish counts and verdict at the end of DECIDE unless the scan is aborted.
  always_ff @(posedge clock) begin
    if (!reset) begin
      result     <= CLR_NONE;
      red_count  <= '0;
      blue_count <= '0;
    end else if (state == ST_DECIDE && !abort) begin
      result     <= verdict;
      red_count  <= red_work;
      blue_count <= blue_work;
    end
  end

endmodule

// File: tb/tb_color_frame_classifier.sv
// Bench for color_frame_classifier. Two instances share the clock and reset:
// a full-size 176x144 one for latency, address walk, ignored starts and
// abort, and a 40x25 (1000 pixel) one running the verdict/boundary table
// with the default MIN_COUNT of 500.
module tb_color_frame_classifier;

  logic        clock = 1'b0;
  logic        rst;
  logic        start_v  [2];
  logic        abort_v  [2];
  logic [7:0]  pix_v    [2];
  logic [14:0] addr_v   [2];
  logic        busy_v   [2];
  logic        done_v   [2];
  logic [1:0]  result_v [2];
  logic [14:0] red_v    [2];
  logic [14:0] blue_v   [2];
  logic [1:0]  st_v     [2];
  int          mode_v   [2];
  int          n_v      [2];

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int mode;
    int n;
    int red;
    int blue;
    int res;
  } vec_t;

  vec_t vecs[9];

  always #5 clock = ~clock;

  color_frame_classifier dut_full (
    .clock(clock), .reset(rst), .start(start_v[0]), .abort(abort_v[0]),
    .pixel_in(pix_v[0]), .read_addr(addr_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .result(result_v[0]), .red_count(red_v[0]),
    .blue_count(blue_v[0]), .fsm_state(st_v[0])
  );

  color_frame_classifier #(.WIDTH(40), .HEIGHT(25)) dut_small (
    .clock(clock), .reset(rst), .start(start_v[1]), .abort(abort_v[1]),
    .pixel_in(pix_v[1]), .read_addr(addr_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .result(result_v[1]), .red_count(red_v[1]),
    .blue_count(blue_v[1]), .fsm_state(st_v[1])
  );

  // Frame contents for each pattern mode.
  function automatic logic [7:0] pixel_at(input int m, input int n, input int w, input int addr);
    int col;
    col = addr % w;
    case (m)
      0: return 8'hE0;                                  // pure red
      1: return (col < w / 2) ? 8'h03 : 8'hE0;          // left blue, right red
      2: return (addr < n) ? 8'h03 : 8'h00;             // first n blue
      3: return 8'h03;                                  // all blue
      4: begin
        case (addr % 4)
          0:       return 8'hA0;                        // R5 G0 B0 red
          1:       return 8'h4A;                        // R2 G2 B2 blue
          2:       return 8'h88;                        // R4 G2 B0 neither
          default: return 8'hA8;                        // R5 G2 B0 red
        endcase
      end
      5: return 8'hA3;                                  // R5 G0 B3 neither
      6: return (addr % 2 == 0) ? 8'hFF : 8'h0B;        // white / R0 G2 B3 blue
      7: return (addr < n) ? 8'h03 : 8'h0F;             // G3 not blue
      default: return 8'h00;
    endcase
  endfunction

  // Registered read port model, one cycle of latency.
  always @(posedge clock) begin
    pix_v[0] <= pixel_at(mode_v[0], n_v[0], 176, int'(addr_v[0]));
    pix_v[1] <= pixel_at(mode_v[1], n_v[1], 40, int'(addr_v[1]));
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // One full frame on instance sel; optionally pokes start mid-scan.
  task automatic run_frame(input int sel, input int m, input int n, input int er,
                           input int eb, input int eres, input bit poke);
    int npix, lat, cyc, done_cyc, done_cnt, addr_bad, busy_bad, exp_addr;
    logic [31:0] e;
    npix = (sel == 0) ? 25344 : 1000;
    lat  = npix + 3;
    exp_q.push_back({2'(eres), 15'(er), 15'(eb)});
    mode_v[sel] = m;
    n_v[sel]    = n;
    @(negedge clock);
    start_v[sel] = 1'b1;
    @(negedge clock);
    start_v[sel] = 1'b0;
    cyc = 2; done_cyc = 0; done_cnt = 0; addr_bad = 0; busy_bad = 0;
    while (done_cyc == 0 && cyc < npix + 50) begin
      exp_addr = (cyc - 2 < npix) ? cyc - 2 : 0;
      if (int'(addr_v[sel]) != exp_addr) addr_bad++;
      if (busy_v[sel] !== 1'b1) busy_bad++;
      if (done_v[sel] === 1'b1) begin
        done_cyc = cyc;
        done_cnt++;
      end
      if (poke) start_v[sel] = (cyc == 5000 || cyc == 5001 || cyc == 20000);
      @(negedge clock);
      cyc++;
    end
    start_v[sel] = 1'b0;
    check("done_latency", done_cyc, lat);
    check("addr_walk_errors", addr_bad, 0);
    check("busy_during_scan_errors", busy_bad, 0);
    check("busy_after_done", busy_v[sel], 0);
    e = exp_q.pop_front();
    check("red_count", red_v[sel], e[29:15]);
    check("blue_count", blue_v[sel], e[14:0]);
    check("result", result_v[sel], e[31:30]);
    for (int i = 0; i < 5; i++) begin
      if (done_v[sel] === 1'b1) done_cnt++;
      if (busy_v[sel] !== 1'b0) busy_bad++;
      @(negedge clock);
    end
    check("done_pulse_count", done_cnt, 1);
    check("idle_after_frame_busy_errors", busy_bad, 0);
  endtask

  initial begin
    int cyc, dones;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      start_v[s] = 1'b1;
      abort_v[s] = 1'b0;
      mode_v[s]  = 0;
      n_v[s]     = 0;
    end

    vecs[0] = '{0,   0, 1000,    0, 1};
    vecs[1] = '{1,   0,  500,  500, 0};
    vecs[2] = '{2, 400,    0,  400, 0};
    vecs[3] = '{2, 600,    0,  600, 2};
    vecs[4] = '{4,   0,  500,  250, 1};
    vecs[5] = '{5,   0,    0,    0, 0};
    vecs[6] = '{6,   0,    0,  500, 2};
    vecs[7] = '{7, 499,    0,  499, 0};
    vecs[8] = '{3,   0,    0, 1000, 2};

    // Reset held with start asserted: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      for (int s = 0; s < 2; s++)
        check("reset_outputs",
              {busy_v[s], done_v[s], result_v[s], red_v[s], blue_v[s], addr_v[s]}, 64'd0);
    end
    @(negedge clock);
    rst = 1'b1;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    @(negedge clock);
    check("idle_after_release", {busy_v[0], busy_v[1]}, 0);

    // Full size: first start after reset, ignored start pulses, row wrap.
    run_frame(0, 0, 0, 25344, 0, 1, 1'b1);

    // Table of verdicts and classification boundaries on the small frame.
    for (int v = 0; v < 9; v++)
      run_frame(1, vecs[v].mode, vecs[v].n, vecs[v].red, vecs[v].blue, vecs[v].res, 1'b0);

    // abort while idle is ignored; start together with abort does not start.
    @(negedge clock);
    abort_v[0] = 1'b1;
    @(negedge clock);
    abort_v[0] = 1'b0;
    check("abort_idle_busy", busy_v[0], 0);
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    check("start_abort_busy", busy_v[0], 0);
    @(negedge clock);
    check("start_abort_busy_later", busy_v[0], 0);

    // Abort at address 10000 of an all-blue scan.
    mode_v[0] = 3;
    start_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    cyc = 0;
    dones = 0;
    while (addr_v[0] != 15'd10000 && cyc < 12000) begin
      if (done_v[0] === 1'b1) dones++;
      @(negedge clock);
      cyc++;
    end
    check("abort_reached_addr", addr_v[0], 10000);
    abort_v[0] = 1'b1;
    @(negedge clock);
    abort_v[0] = 1'b0;
    check("abort_busy_next", busy_v[0], 0);
    check("abort_addr_zero", addr_v[0], 0);
    for (int i = 0; i < 40; i++) begin
      if (done_v[0] === 1'b1 || busy_v[0] !== 1'b0) dones++;
      @(negedge clock);
    end
    check("abort_no_done", dones, 0);
    check("abort_keeps_red", red_v[0], 25344);
    check("abort_keeps_blue", blue_v[0], 0);
    check("abort_keeps_result", result_v[0], 1);

    // Rerun after abort: exact tie at full size.
    run_frame(0, 1, 0, 12672, 12672, 0, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
